button_debounce: RTL and testbench

- Conditions the raw user-area button pads (mprj_io[9:7]) before they reach the Wishbone buttons/LEDs peripheral.
- Per button: 2-flop synchronizer, then a stable-time debounce filter.
- Produces debounced levels, one-cycle press/release pulses, sticky press flags with write-1-to-clear, and a wrapping total-press counter.
- The peripheral reads these outputs as its button status register and drives the clear strobes from Wishbone writes.

---
 rtl/button_debounce.sv | 104 ++++++++++
 tb/tb_button_debounce.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// Raw button conditioning: 2-flop synchronizer and stable-time debounce per bit,
// plus press/release pulses, sticky press flags and a wrapping press counter.
module button_debounce #(
  parameter int NUM_BUTTONS     = 3,
  parameter int DEBOUNCE_CYCLES = 100,
  parameter int CNT_W           = 16
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic [NUM_BUTTONS-1:0] buttons_i,
  output logic [NUM_BUTTONS-1:0] buttons_o,
  output logic [NUM_BUTTONS-1:0] press_o,
  output logic [NUM_BUTTONS-1:0] release_o,
  output logic [NUM_BUTTONS-1:0] event_o,
  input  logic [NUM_BUTTONS-1:0] event_clr_i,
  output logic [7:0]             press_count_o,
  input  logic                   count_clr_i
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BUTTONS-1:0] sync1_reg;
  logic [NUM_BUTTONS-1:0] sync2_reg;
  logic [NUM_BUTTONS-1:0] stable_reg;
  logic [NUM_BUTTONS-1:0] stable_next;
  logic [NUM_BUTTONS-1:0] press_reg;
  logic [NUM_BUTTONS-1:0] press_next;
  logic [NUM_BUTTONS-1:0] release_reg;
  logic [NUM_BUTTONS-1:0] release_next;
  logic [NUM_BUTTONS-1:0] event_reg;
  logic [NUM_BUTTONS-1:0] event_next;
  logic [7:0]             count_reg;
  logic [7:0]             count_next;
  logic [7:0]             press_pop;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= buttons_i;
      sync2_reg <= sync1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             differs;

      // The count only advances while the synchronized level disagrees with
      // the debounced one; any agreement restarts it from zero.
      assign differs          = sync2_reg[gi] != stable_reg[gi];
      assign stable_next[gi]  = (differs && cnt_reg == CNT_MAX) ? sync2_reg[gi] : stable_reg[gi];
      assign cnt_next         = (!differs || cnt_reg == CNT_MAX) ? '0 : cnt_reg + CNT_W'(1);
      assign press_next[gi]   = stable_next[gi] & ~stable_reg[gi];
      assign release_next[gi] = ~stable_next[gi] & stable_reg[gi];

      always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end
    end
  endgenerate

  always_comb begin
    press_pop = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      press_pop = press_pop + 8'(press_next[i]);
    end
  end

  // A new press sets the flag even when a clear arrives in the same cycle.
  assign event_next = press_next | (event_reg & ~event_clr_i);
  assign count_next = (count_clr_i ? 8'd0 : count_reg) + press_pop;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      stable_reg  <= '0;
      press_reg   <= '0;
      release_reg <= '0;
      event_reg   <= '0;
      count_reg   <= '0;
    end else begin
      stable_reg  <= stable_next;
      press_reg   <= press_next;
      release_reg <= release_next;
      event_reg   <= event_next;
      count_reg   <= count_next;
    end
  end

  assign buttons_o     = stable_reg;
  assign press_o       = press_reg;
  assign release_o     = release_reg;
  assign event_o       = event_reg;
  assign press_count_o = count_reg;

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: directed scenarios plus random
// bouncing inputs, all compared against a timestamp-based reference model.
module tb_button_debounce;

  localparam int N = 3;
  localparam int D = 8;

  logic         wb_clk_i = 1'b0;
  logic         wb_rst_i;
  logic [N-1:0] buttons_i;
  logic [N-1:0] buttons_o;
  logic [N-1:0] press_o;
  logic [N-1:0] release_o;
  logic [N-1:0] event_o;
  logic [N-1:0] event_clr_i;
  logic [7:0]   press_count_o;
  logic         count_clr_i;

  button_debounce #(
    .NUM_BUTTONS    (N),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (16)
  ) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .buttons_i    (buttons_i),
    .buttons_o    (buttons_o),
    .press_o      (press_o),
    .release_o    (release_o),
    .event_o      (event_o),
    .event_clr_i  (event_clr_i),
    .press_count_o(press_count_o),
    .count_clr_i  (count_clr_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the debounced level flips once the pad level seen two
  // edges late has disagreed with it for D evaluations since the later of
  // its last change and the last flip.
  logic [N-1:0] hist_q[$];
  int           edge_k;
  int           last_chg[N];
  int           last_flip[N];
  logic [N-1:0] prev_d;
  logic [N-1:0] m_stable;
  logic [N-1:0] m_press;
  logic [N-1:0] m_release;
  logic [N-1:0] m_event;
  logic [7:0]   m_count;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist_q.delete();
    edge_k = 0;
    for (int i = 0; i < N; i++) begin
      last_chg[i]  = 0;
      last_flip[i] = -1;
    end
    prev_d    = '0;
    m_stable  = '0;
    m_press   = '0;
    m_release = '0;
    m_event   = '0;
    m_count   = '0;
  endtask

  task automatic model_edge(input logic [N-1:0] b, input logic [N-1:0] clr,
                            input logic cclr, input logic rst);
    logic [N-1:0] d;
    int start;
    if (rst) begin
      model_reset();
      return;
    end
    d = (hist_q.size() >= 2) ? hist_q[hist_q.size()-2] : '0;
    m_press   = '0;
    m_release = '0;
    for (int i = 0; i < N; i++) begin
      if (d[i] != prev_d[i]) last_chg[i] = edge_k;
      if (d[i] != m_stable[i]) begin
        start = (last_chg[i] > last_flip[i] + 1) ? last_chg[i] : last_flip[i] + 1;
        if (edge_k - start + 1 >= D) begin
          m_stable[i]  = d[i];
          last_flip[i] = edge_k;
          if (d[i]) m_press[i] = 1'b1;
          else      m_release[i] = 1'b1;
        end
      end
    end
    prev_d  = d;
    m_event = m_press | (m_event & ~clr);
    m_count = (cclr ? 8'd0 : m_count) + 8'($countones(m_press));
    hist_q.push_back(b);
    if (hist_q.size() > 2) void'(hist_q.pop_front());
    edge_k++;
  endtask

  task automatic tick();
    logic [N-1:0] b;
    logic [N-1:0] c;
    logic         cc;
    logic         r;
    b  = buttons_i;
    c  = event_clr_i;
    cc = count_clr_i;
    r  = wb_rst_i;
    @(posedge wb_clk_i);
    model_edge(b, c, cc, r);
    #1;
    check("buttons_o", buttons_o, m_stable);
    check("press_o", press_o, m_press);
    check("release_o", release_o, m_release);
    check("event_o", event_o, m_event);
    check("press_count_o", press_count_o, m_count);
    event_clr_i = '0;
    count_clr_i = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  task automatic wait_level(input int bit_i, input logic lvl, input int max_edges, output int edges);
    edges = -1;
    for (int j = 1; j <= max_edges; j++) begin
      tick();
      if (buttons_o[bit_i] == lvl) begin
        edges = j;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int cnt0;
    int seg_left[N];

    model_reset();
    wb_rst_i    = 1'b1;
    buttons_i   = '0;
    event_clr_i = '0;
    count_clr_i = 1'b0;
    ticks(2);
    check("rst_buttons", buttons_o, 0);
    check("rst_count", press_count_o, 0);
    wb_rst_i = 1'b0;
    ticks(3);

    // Clean step on button 0
    buttons_i = 3'b001;
    wait_level(0, 1'b1, 20, lat);
    check("step_latency", lat, 10);
    check("step_press", press_o, 3'b001);
    tick();
    check("step_press_gone", press_o, 0);
    check("step_event", event_o, 3'b001);
    check("step_count", press_count_o, 1);
    $display("[TB] txn step: latency=%0d count=%0d", lat, press_count_o);

    // Bounce on button 1
    cnt0 = press_count_o;
    buttons_i[1] = 1'b1; ticks(5);
    buttons_i[1] = 1'b0; ticks(1);
    buttons_i[1] = 1'b1;
    wait_level(1, 1'b1, 20, lat);
    check("bounce_latency", lat, 10);
    check("bounce_count", press_count_o, cnt0 + 1);
    $display("[TB] txn bounce: latency=%0d count=%0d", lat, press_count_o);

    // Glitch on button 2
    cnt0 = press_count_o;
    buttons_i[2] = 1'b1; ticks(7);
    buttons_i[2] = 1'b0; ticks(15);
    check("glitch_buttons", buttons_o, 3'b011);
    check("glitch_event", event_o, 3'b011);
    check("glitch_count", press_count_o, cnt0);
    $display("[TB] txn glitch: buttons=%b count=%0d", buttons_o, press_count_o);

    // Simultaneous press with counter clear on the press edge, then release
    buttons_i = 3'b000; ticks(12);
    buttons_i = 3'b111; ticks(9);
    count_clr_i = 1'b1;
    tick();
    check("simul_press", press_o, 3'b111);
    check("simul_count", press_count_o, 3);
    tick();
    check("simul_press_gone", press_o, 0);
    buttons_i = 3'b000; ticks(9);
    tick();
    check("simul_release", release_o, 3'b111);
    tick();
    check("simul_release_gone", release_o, 0);
    check("simul_count_hold", press_count_o, 3);
    $display("[TB] txn simultaneous: count=%0d", press_count_o);

    // Clear priority
    event_clr_i = 3'b111; tick();
    check("clr_all", event_o, 0);
    buttons_i = 3'b001; ticks(9);
    event_clr_i = 3'b001;
    tick();
    check("clr_prio_press", press_o, 3'b001);
    check("clr_prio_event", event_o, 3'b001);
    ticks(3);
    event_clr_i = 3'b001;
    tick();
    check("clr_isolated", event_o, 0);
    $display("[TB] txn clear_priority: event=%b", event_o);

    // Wrap after 257 presses, then reset with buttons held high
    count_clr_i = 1'b1; tick();
    check("wrap_cleared", press_count_o, 0);
    for (int p = 0; p < 257; p++) begin
      buttons_i = 3'b000; ticks(11);
      buttons_i = 3'b001; ticks(11);
    end
    check("wrap_count", press_count_o, 1);
    buttons_i = 3'b111;
    wb_rst_i  = 1'b1;
    tick();
    check("rst_mid_buttons", buttons_o, 0);
    check("rst_mid_event", event_o, 0);
    check("rst_mid_count", press_count_o, 0);
    wb_rst_i = 1'b0;
    wait_level(0, 1'b1, 20, lat);
    check("rst_release_latency", lat, 10);
    check("rst_release_buttons", buttons_o, 3'b111);
    $display("[TB] txn wrap_reset: latency=%0d count=%0d", lat, press_count_o);

    // Random bouncing inputs with random strobes and rare resets
    for (int i = 0; i < N; i++) seg_left[i] = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        seg_left[i]--;
        if (seg_left[i] == 0) begin
          buttons_i[i] = ~buttons_i[i];
          seg_left[i]  = $urandom_range(1, 14);
        end
      end
      event_clr_i = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 7)) : '0;
      count_clr_i = ($urandom_range(0, 15) == 0);
      wb_rst_i    = ($urandom_range(0, 499) == 0);
      tick();
    end
    wb_rst_i = 1'b0;
    $display("[TB] txn random: count=%0d", press_count_o);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
